// File: rtl/csp_tree_pkg.sv
// Shared definitions for the 8-leaf CSP routing tree: packet geometry,
// route-header constants and the header builder used by leaves and decoders.
package csp_tree_pkg;

    localparam int PKT_W = 11;
    localparam int HDR_W = 5;
    localparam int ID_W  = 3;

    localparam logic [HDR_W-1:0] HDR_SIBLING    = 5'b10000;
    localparam logic [1:0]       HDR_HALF_BASE  = 2'b01;
    localparam logic [2:0]       HDR_CROSS_BASE = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } tx_state_e;

    // The header encodes how far up the tree the packet climbs before turning down.
    function automatic logic [HDR_W-1:0] route_hdr(input logic [ID_W-1:0] src,
                                                   input logic [ID_W-1:0] dst);
        logic [HDR_W-1:0] hdr;
        if (src[2:1] == dst[2:1]) begin
            hdr = HDR_SIBLING;
        end else if (src[2] == dst[2]) begin
            hdr = {HDR_HALF_BASE, dst[0], 2'b00};
        end else begin
            hdr = {HDR_CROSS_BASE, dst[1:0]};
        end
        return hdr;
    endfunction

endpackage

// File: rtl/csp_pkt_fifo.sv
// Small synchronous packet FIFO; the head entry is visible combinationally
// so the launching FSM can load it on the same edge it pops.
module csp_pkt_fifo
    import csp_tree_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [PKT_W-1:0] push_data,
    input  logic             pop,
    output logic [PKT_W-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/csp_leaf_injector.sv
// Packet source for one leaf of the CSP tree: builds routed packets, queues them
// and drives them out over a 4-phase bundled-data handshake with a synchronized ack.
module csp_leaf_injector
    import csp_tree_pkg::*;
#(
    parameter logic [ID_W-1:0] SRC_ID = 3'd0,
    parameter int              DEPTH  = 4,
    parameter int              CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ID_W-1:0]  in_dst,
    output logic             in_ready,
    output logic [PKT_W-1:0] tx_data,
    output logic             tx_req,
    input  logic             tx_ack,
    output logic [CNT_W-1:0] tx_count,
    output logic             err_self
);

    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_head;
    logic             accept;
    logic             is_self;
    logic             push;
    logic             pop;
    logic [PKT_W-1:0] push_pkt;

    logic             ack_meta_q;
    logic             ack_s_q;
    logic             err_self_q, err_self_d;
    tx_state_e        state_q, state_d;
    logic             tx_req_q, tx_req_d;
    logic [PKT_W-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && !fifo_full;
    assign is_self  = (in_dst == SRC_ID);
    assign push     = accept && !is_self;
    assign push_pkt = {route_hdr(SRC_ID, in_dst), SRC_ID, in_dst};

    csp_pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_pkt),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= tx_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Launch only once the tree has returned to zero, which also covers a reset mid-handshake.
    always_comb begin
        state_d    = state_q;
        tx_req_d   = tx_req_q;
        tx_data_d  = tx_data_q;
        tx_count_d = tx_count_q;
        err_self_d = accept && is_self;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !ack_s_q) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_head;
                    tx_req_d  = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s_q) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s_q) begin
                    tx_count_d = tx_count_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_count_q <= '0;
            err_self_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
            tx_count_q <= tx_count_d;
            err_self_q <= err_self_d;
        end
    end

    assign tx_req   = tx_req_q;
    assign tx_data  = tx_data_q;
    assign tx_count = tx_count_q;
    assign err_self = err_self_q;

endmodule
